// File: rtl/pipe_skid_reg.sv
// Generic inter-stage pipeline register with a valid/ready handshake, a
// two-entry skid buffer, flush, bubble insertion and a saturating stall counter.
module pipe_skid_reg #(
  parameter int                DATA_W    = 160,
  parameter logic [DATA_W-1:0] NOP_VALUE = '0,
  parameter int                CNT_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cycles
);

  logic              main_valid_q, main_valid_d;
  logic [DATA_W-1:0] main_data_q,  main_data_d;
  logic              skid_valid_q, skid_valid_d;
  logic [DATA_W-1:0] skid_data_q,  skid_data_d;
  logic [CNT_W-1:0]  stall_q,      stall_d;
  logic              in_fire, out_fire;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign in_ready     = ~skid_valid_q;
  assign out_valid    = main_valid_q;
  assign out_data     = main_data_q;
  assign stall_cycles = stall_q;

  assign in_fire  = in_valid & ~skid_valid_q;
  assign out_fire = main_valid_q & out_ready;

  always_comb begin
    main_valid_d = main_valid_q;
    main_data_d  = main_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    stall_d      = stall_q;

    if (main_valid_q && !out_ready)
      stall_d = sat_inc(stall_q);

    // Main slot frees up this cycle: refill from skid first to keep FIFO order.
    if (!main_valid_q || out_fire) begin
      if (skid_valid_q) begin
        main_valid_d = 1'b1;
        main_data_d  = skid_data_q;
        skid_valid_d = 1'b0;
      end else if (in_fire) begin
        main_valid_d = 1'b1;
        main_data_d  = in_data;
      end else begin
        main_valid_d = 1'b0;
        main_data_d  = NOP_VALUE;
      end
    end else if (in_fire) begin
      skid_valid_d = 1'b1;
      skid_data_d  = in_data;
    end

    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
      main_data_d  = NOP_VALUE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      main_valid_q <= 1'b0;
      main_data_q  <= NOP_VALUE;
      skid_valid_q <= 1'b0;
      stall_q      <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      main_data_q  <= main_data_d;
      skid_valid_q <= skid_valid_d;
      stall_q      <= stall_d;
    end
  end

  // Skid payload is qualified by skid_valid_q, so it needs no reset.
  always_ff @(posedge clk) begin
    skid_data_q <= skid_data_d;
  end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed bench for pipe_skid_reg: a vector table for streaming, backpressure,
// bubbles and flush, plus hand sequences for counter saturation and mid-stall reset.
module tb_pipe_skid_reg;

  localparam int              DW  = 16;
  localparam int              CW  = 3;
  localparam logic [DW-1:0]   NOP = 16'hDEAD;

  logic          clk = 1'b0;
  logic          reset, flush, in_valid, out_ready;
  logic [DW-1:0] in_data;
  logic          in_ready, out_valid;
  logic [DW-1:0] out_data;
  logic [CW-1:0] stall_cycles;

  int checks = 0;
  int errors = 0;

  pipe_skid_reg #(.DATA_W(DW), .NOP_VALUE(NOP), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic          rst;
    logic          fl;
    logic          iv;
    logic [DW-1:0] d;
    logic          ordy;
    logic          e_ov;
    logic [DW-1:0] e_od;
    logic          e_ir;
    logic [CW-1:0] e_st;
  } row_t;

  row_t vec[$];

  task automatic add(input logic rst, input logic fl, input logic iv, input logic [DW-1:0] d,
                     input logic ordy, input logic e_ov, input logic [DW-1:0] e_od,
                     input logic e_ir, input logic [CW-1:0] e_st);
    row_t r;
    r.rst = rst; r.fl = fl; r.iv = iv; r.d = d; r.ordy = ordy;
    r.e_ov = e_ov; r.e_od = e_od; r.e_ir = e_ir; r.e_st = e_st;
    vec.push_back(r);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic fl, input logic iv,
                       input logic [DW-1:0] d, input logic ordy);
    reset = rst; flush = fl; in_valid = iv; in_data = d; out_ready = ordy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic e_ov, input logic [DW-1:0] e_od,
                         input logic e_ir, input logic [CW-1:0] e_st);
    chk({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, e_ov});
    chk({tag, ".out_data"}, {16'd0, out_data}, {16'd0, e_od});
    chk({tag, ".in_ready"}, {31'd0, in_ready}, {31'd0, e_ir});
    chk({tag, ".stall"}, {29'd0, stall_cycles}, {29'd0, e_st});
  endtask

  initial begin
    drive(1'b1, 1'b0, 1'b0, '0, 1'b1);

    //   rst   fl    iv    data     ordy  e_ov  e_od     e_ir  e_st
    add(1'b1, 1'b0, 1'b0, 16'h0,   1'b1, 1'b0, NOP,     1'b1, 3'd0);
    // streaming 1..4 then bubble
    add(1'b0, 1'b0, 1'b1, 16'h1,   1'b1, 1'b1, 16'h1,   1'b1, 3'd0);
    add(1'b0, 1'b0, 1'b1, 16'h2,   1'b1, 1'b1, 16'h2,   1'b1, 3'd0);
    add(1'b0, 1'b0, 1'b1, 16'h3,   1'b1, 1'b1, 16'h3,   1'b1, 3'd0);
    add(1'b0, 1'b0, 1'b1, 16'h4,   1'b1, 1'b1, 16'h4,   1'b1, 3'd0);
    add(1'b0, 1'b0, 1'b0, 16'h0,   1'b1, 1'b0, NOP,     1'b1, 3'd0);
    // backpressure: B goes to skid, C held upstream, then drain in order
    add(1'b0, 1'b0, 1'b1, 16'hA,   1'b1, 1'b1, 16'hA,   1'b1, 3'd0);
    add(1'b0, 1'b0, 1'b1, 16'hB,   1'b0, 1'b1, 16'hA,   1'b0, 3'd1);
    add(1'b0, 1'b0, 1'b1, 16'hC,   1'b0, 1'b1, 16'hA,   1'b0, 3'd2);
    add(1'b0, 1'b0, 1'b1, 16'hC,   1'b1, 1'b1, 16'hB,   1'b1, 3'd2);
    add(1'b0, 1'b0, 1'b1, 16'hC,   1'b1, 1'b1, 16'hC,   1'b1, 3'd2);
    add(1'b0, 1'b0, 1'b0, 16'h0,   1'b1, 1'b0, NOP,     1'b1, 3'd2);
    // single-beat bubble
    add(1'b0, 1'b0, 1'b1, 16'h55,  1'b1, 1'b1, 16'h55,  1'b1, 3'd2);
    add(1'b0, 1'b0, 1'b0, 16'h0,   1'b1, 1'b0, NOP,     1'b1, 3'd2);
    // flush with both entries full; 0x33 must never appear
    add(1'b0, 1'b0, 1'b1, 16'h11,  1'b0, 1'b1, 16'h11,  1'b1, 3'd2);
    add(1'b0, 1'b0, 1'b1, 16'h22,  1'b0, 1'b1, 16'h11,  1'b0, 3'd3);
    add(1'b0, 1'b1, 1'b1, 16'h33,  1'b0, 1'b0, NOP,     1'b1, 3'd4);
    add(1'b0, 1'b0, 1'b0, 16'h0,   1'b1, 1'b0, NOP,     1'b1, 3'd4);
    // flush coinciding with a real in_fire
    add(1'b0, 1'b1, 1'b1, 16'h44,  1'b0, 1'b0, NOP,     1'b1, 3'd4);
    add(1'b0, 1'b0, 1'b0, 16'h0,   1'b1, 1'b0, NOP,     1'b1, 3'd4);
    // reset and flush together: reset wins, counter cleared
    add(1'b0, 1'b0, 1'b1, 16'h66,  1'b0, 1'b1, 16'h66,  1'b1, 3'd4);
    add(1'b1, 1'b1, 1'b1, 16'h77,  1'b0, 1'b0, NOP,     1'b1, 3'd0);

    foreach (vec[i]) begin
      drive(vec[i].rst, vec[i].fl, vec[i].iv, vec[i].d, vec[i].ordy);
      tick();
      chk_all($sformatf("vec%0d", i), vec[i].e_ov, vec[i].e_od, vec[i].e_ir, vec[i].e_st);
    end

    // Counter saturation: main full, downstream stalled for 10 cycles.
    drive(1'b0, 1'b0, 1'b1, 16'h99, 1'b1);
    tick();
    chk_all("sat_load", 1'b1, 16'h99, 1'b1, 3'd0);
    drive(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
    for (int k = 1; k <= 10; k++) begin
      tick();
      chk_all($sformatf("sat%0d", k), 1'b1, 16'h99, 1'b1, (k > 7) ? 3'd7 : 3'(k));
    end
    drive(1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
    tick();
    chk_all("sat_reset", 1'b0, NOP, 1'b1, 3'd0);

    // Reset mid-stall with both entries full and stall count 5.
    drive(1'b0, 1'b0, 1'b1, 16'h1, 1'b1);
    tick();
    drive(1'b0, 1'b0, 1'b1, 16'h2, 1'b0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
    repeat (4) tick();
    chk_all("mid_full", 1'b1, 16'h1, 1'b0, 3'd5);
    drive(1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
    tick();
    chk_all("mid_reset", 1'b0, NOP, 1'b1, 3'd0);
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 1'b0, 1'b1, 16'h5 + 16'(k), 1'b1);
      tick();
      chk_all($sformatf("resume%0d", k), 1'b1, 16'h5 + 16'(k), 1'b1, 3'd0);
    end
    drive(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
    tick();
    chk_all("resume_end", 1'b0, NOP, 1'b1, 3'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
